// File: rtl/avalon_arb_pkg.sv
// Shared types and width helpers for the SDRAM Avalon-MM arbiter.
package avalon_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ     = 2;
  localparam int unsigned DEF_MAX_PENDING = 4;

  // Owner id width: enough bits to name a requester, never zero.
  function automatic int unsigned owner_id_width(input int unsigned num_req);
    int unsigned w;
    w = $clog2(num_req);
    if (w < 1) w = 1;
    return w;
  endfunction

  // FIFO pointer width: index bits plus one wrap bit for full/empty.
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return w + 1;
  endfunction

  localparam int unsigned OWNER_ID_W = owner_id_width(DEF_NUM_REQ);
  localparam int unsigned FIFO_PTR_W = fifo_ptr_width(DEF_MAX_PENDING);

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which requester issued each outstanding read.
module arb_owner_fifo
  import avalon_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = fifo_ptr_width(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[IDX_W-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Storage and pointers; reset discards every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/avalon_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM slave among NUM_REQ masters,
// with pipelined reads routed back in order through an owner FIFO.
// Optional: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module avalon_sdram_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDRESSWIDTH = 28,
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0]   s_address,
  input  logic [NUM_REQ-1:0]                s_read,
  input  logic [NUM_REQ-1:0]                s_write,
  input  logic [NUM_REQ*DATAWIDTH-1:0]      s_writedata,
  input  logic [NUM_REQ*(DATAWIDTH/8)-1:0]  s_byteenable,
  output logic [NUM_REQ-1:0]                s_waitrequest,
  output logic [DATAWIDTH-1:0]              s_readdata,
  output logic [NUM_REQ-1:0]                s_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]           avm_address,
  output logic                              avm_read,
  output logic                              avm_write,
  output logic [DATAWIDTH-1:0]              avm_writedata,
  output logic [DATAWIDTH/8-1:0]            avm_byteenable,
  input  logic                              avm_waitrequest,
  input  logic [DATAWIDTH-1:0]              avm_readdata,
  input  logic                              avm_readdatavalid,
  output logic                              err_unexpected_rdv
);

  localparam int unsigned ID_W = owner_id_width(NUM_REQ);
  localparam int unsigned BE_W = DATAWIDTH / 8;

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      rdv_q, rdv_d;
  logic                    err_q, err_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         rr_q, rr_d;
  logic [ID_W-1:0]         cand;
`endif

  logic [ADDRESSWIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATAWIDTH-1:0]    wdata_a [NUM_REQ];
  logic [BE_W-1:0]         be_a    [NUM_REQ];
  logic [NUM_REQ-1:0]      elig;
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic [NUM_REQ-1:0]      s_wait_c;
  logic                    push, pop;
  logic                    fifo_full, fifo_empty;
  logic [ID_W-1:0]         fifo_dout;

  // Per-requester payload slices and eligibility (write wins over read).
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_a[g]  = s_address[g*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign wdata_a[g] = s_writedata[g*DATAWIDTH +: DATAWIDTH];
    assign be_a[g]    = s_byteenable[g*BE_W +: BE_W];
    assign elig[g]    = s_write[g] | (s_read[g] & ~fifo_full);
  end

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest eligible index is kept.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end
`else
  // Round robin: first eligible index at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_q) + k) % int'(NUM_REQ));
      if (elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Next-state, command capture, FIFO push and requester stall.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    push     = 1'b0;
    s_wait_c = '1;
`ifndef ARB_FIXED_PRIO_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          addr_d  = addr_a[win_idx];
          wdata_d = wdata_a[win_idx];
          be_d    = be_a[win_idx];
          wr_d    = s_write[win_idx];
          rd_d    = ~s_write[win_idx];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!avm_waitrequest) begin
          s_wait_c[grant_q] = 1'b0;
          push    = rd_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
`endif
        end else if (!s_read[grant_q] && !s_write[grant_q]) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return routing and the sticky unexpected-data flag.
  always_comb begin
    pop     = avm_readdatavalid & ~fifo_empty;
    rdata_d = pop ? avm_readdata : rdata_q;
    rdv_d   = '0;
    if (pop) rdv_d[fifo_dout] = 1'b1;
    err_d   = err_q | (avm_readdatavalid & fifo_empty);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      rdv_q   <= '0;
      err_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      err_q   <= err_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  arb_owner_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (grant_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (fifo_dout)
  );

  assign s_waitrequest      = s_wait_c;
  assign s_readdata         = rdata_q;
  assign s_readdatavalid    = rdv_q;
  assign avm_address        = addr_q;
  assign avm_read           = rd_q;
  assign avm_write          = wr_q;
  assign avm_writedata      = wdata_q;
  assign avm_byteenable     = be_q;
  assign err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Directed bench for avalon_sdram_arbiter (default round-robin build).
module tb_avalon_sdram_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned NV = 23;

  localparam logic [AW-1:0] A0 = 28'h0000010;
  localparam logic [AW-1:0] A1 = 28'h0000200;
  localparam logic [DW-1:0] D0 = 32'hDEADBEEF;
  localparam logic [DW-1:0] D1 = 32'hCAFEF00D;
  localparam logic [DW-1:0] R1 = 32'h11110001;
  localparam logic [DW-1:0] R2 = 32'h22220000;
  localparam logic [DW-1:0] R3 = 32'h33330001;
  localparam logic [DW-1:0] R4 = 32'h44440000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR*AW-1:0]   s_address;
  logic [NR-1:0]      s_read;
  logic [NR-1:0]      s_write;
  logic [NR*DW-1:0]   s_writedata;
  logic [NR*BW-1:0]   s_byteenable;
  logic [NR-1:0]      s_waitrequest;
  logic [DW-1:0]      s_readdata;
  logic [NR-1:0]      s_readdatavalid;
  logic [AW-1:0]      avm_address;
  logic               avm_read;
  logic               avm_write;
  logic [DW-1:0]      avm_writedata;
  logic [BW-1:0]      avm_byteenable;
  logic               avm_waitrequest;
  logic [DW-1:0]      avm_readdata;
  logic               avm_readdatavalid;
  logic               err_unexpected_rdv;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        awr;
    logic        rdv;
    logic [31:0] rdata;
    logic [1:0]  swr;
    logic        ard;
    logic        aw;
    logic [27:0] addr;
    logic [31:0] wd;
    logic [1:0]  srdv;
    logic [31:0] srdata;
    logic        err;
  } vec_t;

  vec_t vt [NV];

  always #5 clk = ~clk;

  assign s_address    = {A1, A0};
  assign s_writedata  = {D1, D0};
  assign s_byteenable = {4'h3, 4'hF};

  avalon_sdram_arbiter #(
    .NUM_REQ      (NR),
    .ADDRESSWIDTH (AW),
    .DATAWIDTH    (DW),
    .MAX_PENDING  (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_address          (s_address),
    .s_read             (s_read),
    .s_write            (s_write),
    .s_writedata        (s_writedata),
    .s_byteenable       (s_byteenable),
    .s_waitrequest      (s_waitrequest),
    .s_readdata         (s_readdata),
    .s_readdatavalid    (s_readdatavalid),
    .avm_address        (avm_address),
    .avm_read           (avm_read),
    .avm_write          (avm_write),
    .avm_writedata      (avm_writedata),
    .avm_byteenable     (avm_byteenable),
    .avm_waitrequest    (avm_waitrequest),
    .avm_readdata       (avm_readdata),
    .avm_readdatavalid  (avm_readdatavalid),
    .err_unexpected_rdv (err_unexpected_rdv)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    bit  stall_bad, wr_seen, hold, found;

    //        rd     wr    awr   rdv   rdata  | swr   ard   aw    addr wd  srdv  srdata err
    vt[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 28'h0, 32'h0, 2'b00, 32'h0, 1'b0};
    vt[1]  = '{2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 28'h0, 32'h0, 2'b00, 32'h0, 1'b0};
    vt[2]  = '{2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1, A0,    D0,    2'b00, 32'h0, 1'b0};
    vt[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, 32'h0, 1'b0};
    vt[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, 32'h0, 1'b0};
    vt[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0, A1,    D1,    2'b00, 32'h0, 1'b0};
    vt[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A1,    D1,    2'b00, 32'h0, 1'b0};
    vt[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 1'b0, A0,    D0,    2'b00, 32'h0, 1'b0};
    vt[8]  = '{2'b11, 2'b00, 1'b0, 1'b1, R1,    2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, 32'h0, 1'b0};
    vt[9]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0, A1,    D1,    2'b10, R1,    1'b0};
    vt[10] = '{2'b11, 2'b00, 1'b0, 1'b1, R2,    2'b11, 1'b0, 1'b0, A1,    D1,    2'b00, R1,    1'b0};
    vt[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 1'b0, A0,    D0,    2'b01, R2,    1'b0};
    vt[12] = '{2'b00, 2'b00, 1'b0, 1'b1, R3,    2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, R2,    1'b0};
    vt[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b10, R3,    1'b0};
    vt[14] = '{2'b00, 2'b00, 1'b0, 1'b1, R4,    2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, R3,    1'b0};
    vt[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b01, R4,    1'b0};
    vt[16] = '{2'b00, 2'b10, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, R4,    1'b0};
    vt[17] = '{2'b00, 2'b10, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, 1'b1, A1,    D1,    2'b00, R4,    1'b0};
    vt[18] = '{2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1, A1,    D1,    2'b00, R4,    1'b0};
    vt[19] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A1,    D1,    2'b00, R4,    1'b0};
    vt[20] = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A1,    D1,    2'b00, R4,    1'b0};
    vt[21] = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, A0,    D0,    2'b00, R4,    1'b0};
    vt[22] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, A0,    D0,    2'b00, R4,    1'b0};

    reset_n           = 1'b0;
    s_read            = '0;
    s_write           = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.swr", 64'(s_waitrequest), 64'h3);
    chk("rst.avm_rw", 64'({avm_read, avm_write}), 64'h0);
    chk("rst.err", 64'(err_unexpected_rdv), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Write, alternating reads with 3-cycle latency, stalled write, dropped read.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      s_read            = vt[i].rd;
      s_write           = vt[i].wr;
      avm_waitrequest   = vt[i].awr;
      avm_readdatavalid = vt[i].rdv;
      avm_readdata      = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("row%0d.swr", i),    64'(s_waitrequest),      64'(vt[i].swr));
      chk($sformatf("row%0d.ard", i),    64'(avm_read),           64'(vt[i].ard));
      chk($sformatf("row%0d.awr", i),    64'(avm_write),          64'(vt[i].aw));
      chk($sformatf("row%0d.addr", i),   64'(avm_address),        64'(vt[i].addr));
      chk($sformatf("row%0d.wd", i),     64'(avm_writedata),      64'(vt[i].wd));
      chk($sformatf("row%0d.srdv", i),   64'(s_readdatavalid),    64'(vt[i].srdv));
      chk($sformatf("row%0d.srdata", i), 64'(s_readdata),         64'(vt[i].srdata));
      chk($sformatf("row%0d.err", i),    64'(err_unexpected_rdv), 64'(vt[i].err));
    end

    // Readdatavalid with nothing outstanding.
    @(posedge clk); #1;
    s_read = '0; s_write = '0; avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h00000077;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("unexp.srdv", 64'(s_readdatavalid), 64'h0);
    chk("unexp.srdata", 64'(s_readdata), 64'(R4));
    chk("unexp.err", 64'(err_unexpected_rdv), 64'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("unexp.sticky", 64'(err_unexpected_rdv), 64'h1);

    // Fill the owner FIFO with requester 0 reads, data held off.
    @(posedge clk); #1;
    s_read = 2'b01;
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      @(negedge clk);
      if (!s_waitrequest[0] && avm_read) acc++;
      @(posedge clk); #1;
    end
    chk("full.accepts", 64'(acc), 64'd4);

    // Fifth read stalls while a requester 1 write still goes through.
    s_write   = 2'b10;
    stall_bad = 1'b0;
    wr_seen   = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!s_waitrequest[0] || avm_read) stall_bad = 1'b1;
      if (!s_waitrequest[1] && avm_write && avm_address == A1 &&
          avm_byteenable == 4'h3 && avm_writedata == D1) wr_seen = 1'b1;
      hold = !s_waitrequest[1];
      @(posedge clk); #1;
      if (hold) s_write = 2'b00;
    end
    chk("full.read_stalled", 64'(stall_bad), 64'h0);
    chk("full.write_granted", 64'(wr_seen), 64'h1);

    // One return frees a slot and the fifth read is issued.
    avm_readdatavalid = 1'b1; avm_readdata = 32'h5A5A0000;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("full.pop_srdv", 64'(s_readdatavalid), 64'h1);
    chk("full.pop_srdata", 64'(s_readdata), 64'h5A5A0000);
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clk);
      if (!s_waitrequest[0] && avm_read && avm_address == A0) found = 1'b1;
    end
    chk("full.fifth_issued", 64'(found), 64'h1);
    @(posedge clk); #1;
    s_read = '0;

    // Drain two, leaving two reads pending.
    avm_readdatavalid = 1'b1; avm_readdata = 32'h00000061;
    @(posedge clk); #1;
    avm_readdata = 32'h00000062;
    @(negedge clk);
    chk("drain1.srdv", 64'(s_readdatavalid), 64'h1);
    chk("drain1.srdata", 64'(s_readdata), 64'h61);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("drain2.srdv", 64'(s_readdatavalid), 64'h1);
    chk("drain2.srdata", 64'(s_readdata), 64'h62);

    // Asynchronous reset with reads pending.
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("mrst.swr", 64'(s_waitrequest), 64'h3);
    chk("mrst.avm_rw", 64'({avm_read, avm_write}), 64'h0);
    chk("mrst.addr", 64'(avm_address), 64'h0);
    chk("mrst.wd", 64'(avm_writedata), 64'h0);
    chk("mrst.be", 64'(avm_byteenable), 64'h0);
    chk("mrst.srdv", 64'(s_readdatavalid), 64'h0);
    chk("mrst.srdata", 64'(s_readdata), 64'h0);
    chk("mrst.err", 64'(err_unexpected_rdv), 64'h0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Pending reads were discarded: a return now is unexpected.
    avm_readdatavalid = 1'b1; avm_readdata = 32'h00000099;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("post_rst.srdv", 64'(s_readdatavalid), 64'h0);
    chk("post_rst.err", 64'(err_unexpected_rdv), 64'h1);
    chk("post_rst.avm_rw", 64'({avm_read, avm_write}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
